// File: rtl/ad80305_pkg.sv
// Shared types and sizing for the AD80305 I/Q snapshot capture block.
package ad80305_pkg;

  localparam int DATA_W = 12;
  localparam int IQ_W   = 2 * DATA_W;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/ad80305_iq_capture_if.sv
// Sample-stream and readout bus of the I/Q capture block, plus FSM state visibility.
interface ad80305_iq_capture_if #(
  parameter int DATA_W = ad80305_pkg::DATA_W,
  parameter int ADDR_W = ad80305_pkg::ADDR_W
);
  // i_iqdata_fp is a valid-only strobe: there is no ready, the capture never
  // back-pressures, and samples outside ARMED/CAPT are dropped. i_rd_en is
  // likewise accepted unconditionally in DONE and answered by o_rd_valid with
  // o_rd_data exactly two cycles later, one read per cycle sustained.
  logic                       i_iqdata_fp;
  logic [DATA_W-1:0]          i_idata;
  logic [DATA_W-1:0]          i_qdata;
  logic                       i_rd_en;
  logic [ADDR_W-1:0]          i_rd_addr;
  logic [2*DATA_W-1:0]        o_rd_data;
  logic                       o_rd_valid;
  ad80305_pkg::cap_state_e    dbg_state;

  modport master (
    output i_iqdata_fp, i_idata, i_qdata, i_rd_en, i_rd_addr,
    input  o_rd_data, o_rd_valid, dbg_state
  );

  modport slave (
    input  i_iqdata_fp, i_idata, i_qdata, i_rd_en, i_rd_addr,
    output o_rd_data, o_rd_valid, dbg_state
  );
endinterface

// File: rtl/ad_dpram_inf.sv
// Simple dual-port block RAM: write port A, registered read port B.
module ad_dpram_inf #(
  parameter int BRAM_WIDTH = 24,
  parameter int BRAM_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clka,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [BRAM_WIDTH-1:0] dina,
  input  logic                  clkb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [BRAM_WIDTH-1:0] doutb
);
  logic [BRAM_WIDTH-1:0] mem [BRAM_DEPTH];

  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    doutb <= mem[addrb];
  end
endmodule

// File: rtl/ad80305_iq_capture.sv
// Programmable-length I/Q snapshot into block RAM with immediate or |I|+|Q| power
// trigger, peak-magnitude tracking and a fixed two-cycle readout path.
module ad80305_iq_capture #(
  parameter int DATA_W = ad80305_pkg::DATA_W,
  parameter int ADDR_W = ad80305_pkg::ADDR_W,
  parameter int DEPTH  = ad80305_pkg::DEPTH
) (
  input  logic                 i_fpga_clk_125p,
  input  logic                 i_fpga_rst_125p,
  ad80305_iq_capture_if.slave  bus,
  input  logic                 i_cap_start,
  input  logic                 i_cap_abort,
  input  logic                 i_trig_mode,
  input  logic [DATA_W:0]      i_trig_thr,
  input  logic [ADDR_W:0]      i_cap_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADDR_W:0]      o_cap_cnt,
  output logic [DATA_W:0]      o_peak
);
  import ad80305_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  cap_state_e            state_q, state_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic                  mode_q, mode_d;
  logic [DATA_W:0]       thr_q, thr_d;
  logic [ADDR_W:0]       wptr_q, wptr_d;
  logic [ADDR_W:0]       cap_cnt_q, cap_cnt_d;
  logic [DATA_W:0]       peak_q, peak_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [2*DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [DATA_W:0]       i_ext, q_ext, i_abs, q_abs, mag_c;
  logic [ADDR_W:0]       len_clamp_c, wptr_inc_c;
  logic                  accept_c, we_c;
  logic [2*DATA_W-1:0]   ram_dout;

  // Sign-extend before negating so |-2048| = 2048 fits and the sum never wraps.
  always_comb begin
    i_ext = {bus.i_idata[DATA_W-1], bus.i_idata};
    q_ext = {bus.i_qdata[DATA_W-1], bus.i_qdata};
    i_abs = i_ext[DATA_W] ? (~i_ext + 1'b1) : i_ext;
    q_abs = q_ext[DATA_W] ? (~q_ext + 1'b1) : q_ext;
    mag_c = i_abs + q_abs;
  end

  always_comb begin
    len_clamp_c = ((i_cap_len == '0) || (i_cap_len > DEPTH_L)) ? DEPTH_L : i_cap_len;
    wptr_inc_c  = wptr_q + 1'b1;
    accept_c    = bus.i_iqdata_fp &&
                  ((state_q == ST_CAPT) ||
                   ((state_q == ST_ARMED) && (!mode_q || (mag_c >= thr_q))));
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    wptr_d    = wptr_q;
    cap_cnt_d = cap_cnt_q;
    peak_d    = peak_q;
    we_c      = 1'b0;

    if (i_cap_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_cap_start) begin
            state_d   = ST_ARMED;
            len_d     = len_clamp_c;
            mode_d    = i_trig_mode;
            thr_d     = i_trig_thr;
            wptr_d    = '0;
            cap_cnt_d = '0;
            peak_d    = '0;
          end
        end
        ST_ARMED, ST_CAPT: begin
          // In ARMED the pointer is still 0, so the trigger sample lands at address 0.
          if (accept_c) begin
            we_c   = 1'b1;
            wptr_d = wptr_inc_c;
            peak_d = (mag_c > peak_q) ? mag_c : peak_q;
            if (wptr_inc_c == len_q) begin
              state_d   = ST_DONE;
              cap_cnt_d = len_q;
            end else begin
              state_d = ST_CAPT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Readout pipeline is never flushed, so a read accepted in DONE always completes.
  always_comb begin
    rd_pend_d  = bus.i_rd_en && (state_q == ST_DONE);
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? ram_dout : rd_data_q;
  end

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      mode_q     <= 1'b0;
      thr_q      <= '0;
      wptr_q     <= '0;
      cap_cnt_q  <= '0;
      peak_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      wptr_q     <= wptr_d;
      cap_cnt_q  <= cap_cnt_d;
      peak_q     <= peak_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  ad_dpram_inf #(
    .BRAM_WIDTH (2*DATA_W),
    .BRAM_DEPTH (DEPTH),
    .ADDR_WIDTH (ADDR_W)
  ) u_ram (
    .clka  (i_fpga_clk_125p),
    .wea   (we_c),
    .addra (wptr_q[ADDR_W-1:0]),
    .dina  ({bus.i_qdata, bus.i_idata}),
    .clkb  (i_fpga_clk_125p),
    .addrb (bus.i_rd_addr),
    .doutb (ram_dout)
  );

  assign o_busy         = (state_q == ST_ARMED) || (state_q == ST_CAPT);
  assign o_done         = (state_q == ST_DONE);
  assign o_cap_cnt      = cap_cnt_q;
  assign o_peak         = peak_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.dbg_state  = state_q;
endmodule
